// File: rtl/vga_dither_ctrl.sv
// vga_dither_ctrl: pixel phase tracker, frame-synchronous config register and hsync watchdog
// for the 24->12 bit VGA dither datapath. Define VGA_DITHER_4X4_EN to add the 4x4 threshold table.
module vga_dither_ctrl #(
   parameter int unsigned HSYNC_TIMEOUT = 4096,
   parameter int unsigned TO_W          = 13
) (
   input  logic       I_clk,
   input  logic       I_reset_n,
   input  logic       I_cfg_we,
   input  logic [7:0] I_cfg_data,
   output logic [7:0] O_cfg_data,
   output logic       O_cfg_pending,
   input  logic       I_hsync,
   input  logic       I_vsync,
   input  logic       I_de,
   output logic       O_hsync,
   output logic       O_vsync,
   output logic       O_de,
   output logic [3:0] O_threshold,
   output logic       O_bypass,
   output logic       O_locked
);

   typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

`ifdef VGA_DITHER_4X4_EN
   localparam logic [2:0] CFG_MASK = 3'b111;
`else
   localparam logic [2:0] CFG_MASK = 3'b011;
`endif

   state_t            state, state_next;
   logic              hs_q, vs_q, de_q;
   logic              hs_rise, vs_rise;
   logic [2:0]        shadow, active;
   logic              pending;
   logic [1:0]        col, row;
   logic              frame;
   logic [TO_W-1:0]   wd;
   logic              wd_expired;
   logic              odd_phase;
   logic [3:0]        thr_q, thr_next;
   logic              byp_q, byp_next;
   logic              unused_ok;

   assign hs_rise    = I_hsync & ~hs_q;
   assign vs_rise    = I_vsync & ~vs_q;
   assign wd_expired = (wd == TO_W'(HSYNC_TIMEOUT));
   assign unused_ok  = ^{I_cfg_data[7:3], row[1]};

   function automatic logic [3:0] tbl2(input logic odd, input logic [1:0] idx);
      logic [3:0] t;
      case (idx)
         2'b00:   t = odd ? 4'd7  : 4'd15;
         2'b01:   t = odd ? 4'd11 : 4'd3;
         2'b10:   t = odd ? 4'd3  : 4'd11;
         default: t = odd ? 4'd15 : 4'd7;
      endcase
      return t;
   endfunction

`ifdef VGA_DITHER_4X4_EN
   function automatic logic [3:0] tbl4(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] t;
      case ({r, c})
         4'h0: t = 4'd1;  4'h1: t = 4'd9;  4'h2: t = 4'd3;  4'h3: t = 4'd11;
         4'h4: t = 4'd13; 4'h5: t = 4'd5;  4'h6: t = 4'd15; 4'h7: t = 4'd7;
         4'h8: t = 4'd4;  4'h9: t = 4'd12; 4'ha: t = 4'd2;  4'hb: t = 4'd10;
         4'hc: t = 4'd15; 4'hd: t = 4'd8;  4'he: t = 4'd14; default: t = 4'd6;
      endcase
      return t;
   endfunction
`endif

   always_comb begin
      state_next = state;
      case (state)
         UNLOCKED: if (vs_rise)    state_next = LOCKED;
         LOCKED:   if (wd_expired) state_next = UNLOCKED;
         default:                  state_next = UNLOCKED;
      endcase
   end

   // Threshold and bypass are registered together so O_threshold is 0 whenever O_bypass is 1.
   always_comb begin
      odd_phase = active[1] & frame;
      byp_next  = (state == UNLOCKED) | ~active[0];
      thr_next  = tbl2(odd_phase, {row[0], col[0]});
`ifdef VGA_DITHER_4X4_EN
      if (active[2]) thr_next = tbl4(odd_phase ? (row ^ 2'b10) : row, col);
`endif
      if (byp_next) thr_next = '0;
   end

   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         state <= UNLOCKED;
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
         de_q  <= 1'b0;
         thr_q <= '0;
         byp_q <= 1'b1;
      end else begin
         state <= state_next;
         hs_q  <= I_hsync;
         vs_q  <= I_vsync;
         de_q  <= I_de;
         thr_q <= thr_next;
         byp_q <= byp_next;
      end
   end

   // A write landing on the apply cycle still commits the old shadow and re-arms pending.
   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else begin
         if (pending && (vs_rise || state == UNLOCKED)) begin
            active  <= shadow;
            pending <= 1'b0;
         end
         if (I_cfg_we) begin
            shadow  <= I_cfg_data[2:0] & CFG_MASK;
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         col   <= '0;
         row   <= '0;
         frame <= 1'b0;
         wd    <= '0;
      end else if (state == UNLOCKED) begin
         col   <= '0;
         row   <= '0;
         frame <= 1'b0;
         wd    <= '0;
      end else begin
         if (vs_rise) begin
            col   <= '0;
            row   <= '0;
            frame <= ~frame;
         end else if (hs_rise) begin
            col <= '0;
            row <= row + 2'd1;
         end else if (I_de) begin
            col <= col + 2'd1;
         end
         if (hs_rise)          wd <= '0;
         else if (!wd_expired) wd <= wd + 1'b1;
      end
   end

   assign O_cfg_data    = {5'b0, active};
   assign O_cfg_pending = pending;
   assign O_hsync       = hs_q;
   assign O_vsync       = vs_q;
   assign O_de          = de_q;
   assign O_threshold   = thr_q;
   assign O_bypass      = byp_q;
   assign O_locked      = (state == LOCKED);

endmodule

// File: tb/tb_vga_dither_ctrl.sv
// Scoreboard bench for vga_dither_ctrl: randomized video timing and config writes checked
// cycle by cycle against a behavioural model. Honours VGA_DITHER_4X4_EN like the design.
module tb_vga_dither_ctrl;

   localparam int TIMEOUT = 4096;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [7:0] cfg_wdata = '0;
   logic [7:0] cfg_rdata;
   logic       cfg_pending;
   logic       hsync = 1'b0, vsync = 1'b0, de = 1'b0;
   logic       hsync_o, vsync_o, de_o;
   logic [3:0] threshold;
   logic       bypass, locked;

   vga_dither_ctrl #(.HSYNC_TIMEOUT(TIMEOUT), .TO_W(13)) dut (
      .I_clk(clk), .I_reset_n(rst_n),
      .I_cfg_we(cfg_we), .I_cfg_data(cfg_wdata),
      .O_cfg_data(cfg_rdata), .O_cfg_pending(cfg_pending),
      .I_hsync(hsync), .I_vsync(vsync), .I_de(de),
      .O_hsync(hsync_o), .O_vsync(vsync_o), .O_de(de_o),
      .O_threshold(threshold), .O_bypass(bypass), .O_locked(locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       hs, vs, de;
      logic [3:0] thr;
      logic       byp, lock;
      logic [7:0] cfg;
      logic       pend;
   } exp_t;

   exp_t q[$];
   int tests = 0;
   int fails = 0;

   int tab2_even[4] = '{15, 3, 11, 7};
   int tab2_odd[4]  = '{7, 11, 3, 15};
   int tab4[16]     = '{1, 9, 3, 11, 13, 5, 15, 7, 4, 12, 2, 10, 15, 8, 14, 6};

   // Model state: plain integers describing what the video stream has shown so far.
   int m_locked, m_since_hs, m_col, m_row, m_frame;
   int m_act, m_shadow, m_pend, m_prev_hs, m_prev_vs;

`ifdef VGA_DITHER_4X4_EN
   localparam int CFG_MASK = 7;
`else
   localparam int CFG_MASK = 3;
`endif

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_threshold();
      int odd;
      odd = ((m_act / 2) % 2 == 1) && (m_frame == 1);
      if (CFG_MASK == 7 && (m_act / 4) % 2 == 1)
         return tab4[(odd ? (m_row ^ 2) : m_row) * 4 + m_col];
      return odd ? tab2_odd[(m_row % 2) * 2 + (m_col % 2)] : tab2_even[(m_row % 2) * 2 + (m_col % 2)];
   endfunction

   task automatic model_reset();
      m_locked = 0; m_since_hs = 0; m_col = 0; m_row = 0; m_frame = 0;
      m_act = 0; m_shadow = 0; m_pend = 0; m_prev_hs = 0; m_prev_vs = 0;
   endtask

   task automatic model_step(input int hs, input int vs, input int d, input int we, input int data);
      exp_t e;
      int hr, vr, byp, n_act, n_pend, n_locked;
      hr  = hs && !m_prev_hs;
      vr  = vs && !m_prev_vs;
      byp = !m_locked || (m_act % 2 == 0);
      e.hs = hs[0]; e.vs = vs[0]; e.de = d[0];
      e.byp = byp[0];
      e.thr = byp ? 4'd0 : 4'(ref_threshold());
      n_act = m_act; n_pend = m_pend;
      if (m_pend && (vr || !m_locked)) begin n_act = m_shadow; n_pend = 0; end
      if (we) begin m_shadow = data & CFG_MASK; n_pend = 1; end
      if (!m_locked) begin
         n_locked = vr;
         m_col = 0; m_row = 0; m_frame = 0; m_since_hs = 0;
      end else begin
         n_locked = (m_since_hs < TIMEOUT);
         if (vr) begin m_col = 0; m_row = 0; m_frame = 1 - m_frame; end
         else if (hr) begin m_col = 0; m_row = (m_row + 1) % 4; end
         else if (d) m_col = (m_col + 1) % 4;
         m_since_hs = hr ? 0 : (m_since_hs < TIMEOUT ? m_since_hs + 1 : TIMEOUT);
      end
      m_locked = n_locked; m_act = n_act; m_pend = n_pend;
      m_prev_hs = hs; m_prev_vs = vs;
      e.lock = m_locked[0];
      e.cfg  = 8'(m_act);
      e.pend = m_pend[0];
      q.push_back(e);
   endtask

   task automatic drive(input logic hs, input logic vs, input logic d, input logic we, input logic [7:0] data);
      hsync = hs; vsync = vs; de = d; cfg_we = we; cfg_wdata = data;
      model_step(int'(hs), int'(vs), int'(d), int'(we), int'(data));
   endtask

   task automatic step(input logic hs, input logic vs, input logic d, input logic we, input logic [7:0] data);
      @(negedge clk);
      drive(hs, vs, d, we, data);
   endtask

   // One frame: vsync rises together with the first hsync, then lines of random DE length.
   task automatic frame(input int lines, input int wr_rate, input bit wr_first, input logic [7:0] wr_data);
      int n;
      logic we;
      logic [7:0] wd;
      for (int l = 0; l < lines; l++) begin
         n = $urandom_range(9, 4);
         for (int k = 0; k < n + 7; k++) begin
            we = 1'b0; wd = 8'($urandom);
            if (wr_first && l == 0 && k == 0) begin we = 1'b1; wd = wr_data; end
            else if (wr_rate > 0 && $urandom_range(wr_rate - 1, 0) == 0) we = 1'b1;
            step(k < 2, l == 0 && k < 3, k >= 4 && k < 4 + n, we, wd);
         end
      end
   endtask

   task automatic write_mid(input logic [7:0] data);
      step(1'b0, 1'b0, 1'b0, 1'b1, data);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_cfg"}, cfg_rdata, 8'h00);
      check({tag, "_pending"}, 8'(cfg_pending), 8'd0);
      check({tag, "_sync"}, {5'b0, hsync_o, vsync_o, de_o}, 8'd0);
      check({tag, "_thr"}, 8'(threshold), 8'd0);
      check({tag, "_bypass"}, 8'(bypass), 8'd1);
      check({tag, "_locked"}, 8'(locked), 8'd0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("hsync_o", 8'(hsync_o), 8'(e.hs));
            check("vsync_o", 8'(vsync_o), 8'(e.vs));
            check("de_o", 8'(de_o), 8'(e.de));
            check("locked", 8'(locked), 8'(e.lock));
            check("bypass", 8'(bypass), 8'(e.byp));
            check("cfg_data", cfg_rdata, e.cfg);
            check("cfg_pending", 8'(cfg_pending), 8'(e.pend));
            if (e.de) check("threshold", 8'(threshold), 8'(e.thr));
         end
      end
   end

   initial begin : driver
      model_reset();
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      for (int f = 0; f < 3; f++) frame(6, 0, 1'b0, 8'h00);
      write_mid(8'h01);
      for (int f = 0; f < 3; f++) frame(6, 0, 1'b0, 8'h00);
      write_mid(8'h03);
      for (int f = 0; f < 4; f++) frame(6, 0, 1'b0, 8'h00);
      write_mid(8'h05);
      for (int f = 0; f < 3; f++) frame(6, 0, 1'b0, 8'h00);
      frame(6, 0, 1'b1, 8'h07);
      for (int f = 0; f < 3; f++) frame(6, 0, 1'b0, 8'h00);
      for (int f = 0; f < 8; f++) frame(6, 40, 1'b0, 8'h00);

      write_mid(8'h03);
      frame(6, 0, 1'b0, 8'h00);
      for (int k = 0; k < TIMEOUT + 60; k++) step(1'b0, 1'b0, 1'($urandom), 1'b0, 8'h00);
      for (int f = 0; f < 3; f++) frame(6, 0, 1'b0, 8'h00);

      frame(3, 0, 1'b0, 8'h00);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_values("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      write_mid(8'h01);
      for (int f = 0; f < 4; f++) frame(6, 30, 1'b0, 8'h00);

      @(posedge clk);
      #2;
      check("queue_drained", 8'(q.size()), 8'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
